imm_dual_sched: RTL and testbench

//  Time-multiplexes one shared imm_gen instance between the two decode slots of a bundle.

---
 rtl/imm_dual_sched_if.sv | 32 +++
 rtl/imm_dual_sched.sv | 70 +++++++
 tb/tb_imm_dual_sched.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/imm_dual_sched_if.sv
// imm_dual_sched_if: bundle-in, shared imm_gen and result-out signals of imm_dual_sched
interface imm_dual_sched_if #(
   parameter int INSN_LEN       = 32,
   parameter int DATA_LEN       = 32,
   parameter int IMM_TYPE_WIDTH = 2
);
   logic                      flush;
   logic                      in_valid;
   logic                      in_ready;
   logic [INSN_LEN-1:0]       inst1;
   logic [INSN_LEN-1:0]       inst2;
   logic [IMM_TYPE_WIDTH-1:0] imm_type1;
   logic [IMM_TYPE_WIDTH-1:0] imm_type2;
   logic                      uses_imm1;
   logic                      uses_imm2;
   logic [INSN_LEN-1:0]       gen_inst;
   logic [IMM_TYPE_WIDTH-1:0] gen_type;
   logic [DATA_LEN-1:0]       gen_imm;
   logic                      out_valid;
   logic                      out_ready;
   logic [DATA_LEN-1:0]       imm1;
   logic [DATA_LEN-1:0]       imm2;
   logic [31:0]               gen_count;
   modport slave (
      input  flush, in_valid, inst1, inst2, imm_type1, imm_type2, uses_imm1, uses_imm2, gen_imm, out_ready,
      output in_ready, gen_inst, gen_type, out_valid, imm1, imm2, gen_count
   );
   modport master (
      output flush, in_valid, inst1, inst2, imm_type1, imm_type2, uses_imm1, uses_imm2, gen_imm, out_ready,
      input  in_ready, gen_inst, gen_type, out_valid, imm1, imm2, gen_count
   );
endinterface

// File: rtl/imm_dual_sched.sv
// imm_dual_sched: time-multiplexes one shared imm_gen across the two slots of a decode bundle
module imm_dual_sched #(
   parameter int INSN_LEN       = 32,
   parameter int DATA_LEN       = 32,
   parameter int IMM_TYPE_WIDTH = 2
) (
   input logic             clk,
   input logic             reset,
   imm_dual_sched_if.slave s
);
   typedef enum logic [1:0] {IDLE, GEN1, GEN2, DONE} state_t;
   state_t                    state, nxt, first;
   logic                      accept;
   logic [INSN_LEN-1:0]       inst1_q, inst2_q;
   logic [IMM_TYPE_WIDTH-1:0] type1_q, type2_q;
   logic                      uses1_q, uses2_q;
   logic [DATA_LEN-1:0]       imm1_q, imm2_q;
   logic [31:0]               cnt_q;
   always_comb begin
      s.in_ready = !reset && !s.flush && (state == IDLE || (state == DONE && s.out_ready));
      accept     = s.in_valid && s.in_ready;
      first      = s.uses_imm1 ? GEN1 : s.uses_imm2 ? GEN2 : DONE;
      nxt        = s.flush ? IDLE :
                   accept ? first :
                   state == GEN1 ? (uses2_q ? GEN2 : DONE) :
                   state == GEN2 ? DONE :
                   (state == DONE && !s.out_ready) ? DONE : IDLE;
      s.gen_inst  = state == GEN1 ? inst1_q : state == GEN2 ? inst2_q : '0;
      s.gen_type  = state == GEN1 ? type1_q : state == GEN2 ? type2_q : '0;
      s.out_valid = state == DONE;
      s.imm1      = imm1_q;
      s.imm2      = imm2_q;
      s.gen_count = cnt_q;
   end
   // a flush during GEN1/GEN2 still lets that edge's capture and count land
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         inst1_q <= '0;
         inst2_q <= '0;
         type1_q <= '0;
         type2_q <= '0;
         uses1_q <= 1'b0;
         uses2_q <= 1'b0;
         imm1_q  <= '0;
         imm2_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state <= nxt;
         if (accept) begin
            inst1_q <= s.inst1;
            inst2_q <= s.inst2;
            type1_q <= s.imm_type1;
            type2_q <= s.imm_type2;
            uses1_q <= s.uses_imm1;
            uses2_q <= s.uses_imm2;
            imm1_q  <= '0;
            imm2_q  <= '0;
         end
         if (state == GEN1) begin
            imm1_q <= s.gen_imm;
            cnt_q  <= cnt_q + 32'd1;
         end
         if (state == GEN2) begin
            imm2_q <= s.gen_imm;
            cnt_q  <= cnt_q + 32'd1;
         end
      end
   end
endmodule

// File: tb/tb_imm_dual_sched.sv
// tb_imm_dual_sched: directed vectors for imm_dual_sched with an RV32 imm_gen stand-in
module tb_imm_dual_sched;
   localparam logic [1:0] IMM_I = 2'd0, IMM_S = 2'd1, IMM_U = 2'd2, IMM_J = 2'd3;
   logic clk = 1'b0;
   logic reset;
   int   errors = 0, checks = 0, cnt;
   imm_dual_sched_if bus ();
   imm_dual_sched dut (.clk(clk), .reset(reset), .s(bus.slave));
   always #5 clk = ~clk;
   function automatic logic [31:0] imm_of(input logic [31:0] i, input logic [1:0] t);
      case (t)
         IMM_I:   imm_of = {{20{i[31]}}, i[31:20]};
         IMM_S:   imm_of = {{20{i[31]}}, i[31:25], i[11:7]};
         IMM_U:   imm_of = {i[31:12], 12'b0};
         default: imm_of = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
      endcase
   endfunction
   always_comb bus.gen_imm = imm_of(bus.gen_inst, bus.gen_type);
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic drive(input logic v, input logic u1, input logic [31:0] i1, input logic [1:0] t1,
                        input logic u2, input logic [31:0] i2, input logic [1:0] t2);
      bus.in_valid  = v;
      bus.uses_imm1 = u1;
      bus.inst1     = i1;
      bus.imm_type1 = t1;
      bus.uses_imm2 = u2;
      bus.inst2     = i2;
      bus.imm_type2 = t2;
   endtask
   initial begin
      reset = 1'b1;
      bus.flush = 1'b0;
      bus.out_ready = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      check("rst_out_valid", 32'(bus.out_valid), 0);
      check("rst_imm1", bus.imm1, 0);
      check("rst_imm2", bus.imm2, 0);
      check("rst_count", bus.gen_count, 0);
      check("rst_in_ready", 32'(bus.in_ready), 0);
      reset = 1'b0;
      // both slots: I then U
      drive(1, 1, 32'hFFF00093, IMM_I, 1, 32'h000012B7, IMM_U);
      #1 check("t1_in_ready", 32'(bus.in_ready), 1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("t1_gen1_inst", bus.gen_inst, 32'hFFF00093);
      check("t1_gen1_busy", 32'(bus.in_ready), 0);
      check("t1_n1_valid", 32'(bus.out_valid), 0);
      @(negedge clk);
      check("t1_gen2_type", 32'(bus.gen_type), 32'(IMM_U));
      check("t1_n2_valid", 32'(bus.out_valid), 0);
      @(negedge clk);
      check("t1_n3_valid", 32'(bus.out_valid), 1);
      check("t1_imm1", bus.imm1, 32'hFFFFFFFF);
      check("t1_imm2", bus.imm2, 32'h00001000);
      check("t1_count", bus.gen_count, 2);
      check("t1_done_inst", bus.gen_inst, 0);
      @(negedge clk);
      check("t1_idle_valid", 32'(bus.out_valid), 0);
      // slot 2 only: S
      drive(1, 0, 32'h12345678, IMM_I, 1, 32'h0020A423, IMM_S);
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("t2_skip_gen1", bus.gen_inst, 32'h0020A423);
      check("t2_n1_valid", 32'(bus.out_valid), 0);
      @(negedge clk);
      check("t2_n2_valid", 32'(bus.out_valid), 1);
      check("t2_imm1", bus.imm1, 0);
      check("t2_imm2", bus.imm2, 32'h00000008);
      check("t2_count", bus.gen_count, 3);
      @(negedge clk);
      // no immediates, back-to-back
      drive(1, 0, 32'h1, IMM_I, 0, 32'h2, IMM_I);
      cnt = 0;
      for (int k = 0; k < 4; k++) begin
         #1 if (bus.in_valid && bus.in_ready) cnt++;
         @(negedge clk);
         check("t3_valid", 32'(bus.out_valid), 1);
      end
      bus.in_valid = 1'b0;
      check("t3_accepts", cnt, 4);
      check("t3_imm2_clr", bus.imm2, 0);
      check("t3_count", bus.gen_count, 3);
      @(negedge clk);
      check("t3_idle", 32'(bus.out_valid), 0);
      // backpressure on a J bundle
      drive(1, 1, 32'hFFDFF06F, IMM_J, 0, 0, IMM_I);
      bus.out_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      cnt = 0;
      for (int k = 0; k < 5; k++) begin
         check("t4_valid", 32'(bus.out_valid), 1);
         check("t4_imm1", bus.imm1, 32'hFFFFFFFC);
         check("t4_in_ready", 32'(bus.in_ready), 0);
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      bus.in_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (bus.out_valid && bus.out_ready) cnt++;
         @(negedge clk);
      end
      check("t4_handshakes", cnt, 1);
      check("t4_count", bus.gen_count, 4);
      // flush in GEN1
      drive(1, 1, 32'hFFF00093, IMM_I, 1, 32'h000012B7, IMM_U);
      @(negedge clk);
      drive(1, 0, 32'h5, IMM_I, 0, 32'h6, IMM_I);
      bus.flush = 1'b1;
      #1 check("t5_flush_ready", 32'(bus.in_ready), 0);
      @(negedge clk);
      bus.flush = 1'b0;
      check("t5_idle_valid", 32'(bus.out_valid), 0);
      check("t5_idle_inst", bus.gen_inst, 0);
      check("t5_count", bus.gen_count, 5);
      #1 check("t5_reaccept", 32'(bus.in_ready), 1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("t5_new_valid", 32'(bus.out_valid), 1);
      check("t5_imm1_clr", bus.imm1, 0);
      @(negedge clk);
      // wrap then reset in GEN2
      force dut.cnt_q = 32'hFFFFFFFF;
      drive(1, 1, 32'hFFF00093, IMM_I, 0, 0, IMM_I);
      @(negedge clk);
      release dut.cnt_q;
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("t6_wrap", bus.gen_count, 0);
      check("t6_imm1", bus.imm1, 32'hFFFFFFFF);
      @(negedge clk);
      drive(1, 1, 32'hFFDFF06F, IMM_J, 1, 32'h0020A423, IMM_S);
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("t6_gen2", bus.gen_inst, 32'h0020A423);
      reset = 1'b1;
      @(negedge clk);
      check("t6_rst_valid", 32'(bus.out_valid), 0);
      check("t6_rst_imm1", bus.imm1, 0);
      check("t6_rst_imm2", bus.imm2, 0);
      check("t6_rst_count", bus.gen_count, 0);
      check("t6_rst_inst", bus.gen_inst, 0);
      reset = 1'b0;
      @(negedge clk);
      check("t6_idle_ready", 32'(bus.in_ready), 1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
